sc_randq_range_sampler: RTL and testbench

//  Downstream consumer of the 8-bit pseudo-random shifter output. On each sample tick it captures
//  one random byte, rejects values that would bias the result, and reduces the rest modulo RANGE
//  by iterative subtraction. Each result index (0..RANGE-1) is queued in a small FIFO and handed
//  to game/display logic over a valid/ready handshake.

---
 rtl/sc_randq_range_sampler_pkg.sv | 26 ++
 rtl/sc_randq_fifo.sv | 73 +++++++
 rtl/sc_randq_range_sampler.sv | 126 ++++++++++++
 tb/tb_sc_randq_range_sampler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_randq_range_sampler_pkg.sv
// Shared definitions for the random range sampler: FSM encoding and sizing helpers.
package sc_randq_range_sampler_pkg;

   // Sampler FSM encoding
   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StReduce = 2'd1;
   localparam logic [1:0] StPush   = 2'd2;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int unsigned f_clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Largest multiple of range that fits in the input byte space; values at or above it bias
   // the modulo result and are rejected
   function automatic int unsigned f_limit(input int unsigned data_width,
                                           input int unsigned range);
      return range * ((32'd1 << data_width) / range);
   endfunction

endpackage

// File: rtl/sc_randq_fifo.sv
// Show-ahead synchronous FIFO with a registered head that holds its last value when empty.
module sc_randq_fifo
   import sc_randq_range_sampler_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned IDXWIDTH = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [IDXWIDTH-1:0]       i_wdata,
   output logic [IDXWIDTH-1:0]       o_head,
   output logic [f_clog2(DEPTH):0]   o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int unsigned PTRW = f_clog2(DEPTH);
   localparam int unsigned CNTW = PTRW + 1;

   logic [IDXWIDTH-1:0] r_mem [DEPTH];
   logic [PTRW-1:0]     r_wr_ptr;
   logic [PTRW-1:0]     r_rd_ptr;
   logic [CNTW-1:0]     r_count;
   logic [IDXWIDTH-1:0] r_head;
   logic [PTRW-1:0]     w_rd_ptr_nx;
   logic                w_pop;
   logic                w_push;

   assign o_full      = (r_count == CNTW'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign w_pop       = i_pop && !o_empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign w_push      = i_push && (!o_full || w_pop);
   assign w_rd_ptr_nx = r_rd_ptr + PTRW'(1);

   // Storage array; no reset needed since the pointers define what is valid
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_ptr_nx;
         if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNTW'(1);
         // Head follows the next stored entry, or the incoming write when it becomes the head
         if (w_pop) begin
            if (r_count == CNTW'(1)) begin
               if (w_push) r_head <= i_wdata;
            end else begin
               r_head <= r_mem[w_rd_ptr_nx];
            end
         end else if (w_push && o_empty) begin
            r_head <= i_wdata;
         end
      end
   end

   assign o_head  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/sc_randq_range_sampler.sv
// Unbiased range sampler: rejects high random bytes, reduces the rest modulo RANGE by repeated
// subtraction and queues the resulting indices for a valid/ready consumer.
module sc_randq_range_sampler
   import sc_randq_range_sampler_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned RANGE     = 6,
   parameter int unsigned IDXWIDTH  = 3,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                     SC_RANDQ_CLOCK_50,
   input  logic                     SC_RANDQ_RESET_InLow,
   input  logic [DATAWIDTH-1:0]     SC_RANDQ_random_InBUS,
   input  logic                     SC_RANDQ_sampleTick_In,
   input  logic                     SC_RANDQ_clear_In,
   input  logic                     SC_RANDQ_ready_In,
   output logic [IDXWIDTH-1:0]      SC_RANDQ_data_OutBUS,
   output logic                     SC_RANDQ_valid_Out,
   output logic [f_clog2(DEPTH):0]  SC_RANDQ_count_OutBUS,
   output logic                     SC_RANDQ_busy_Out,
   output logic                     SC_RANDQ_overrun_Out,
   output logic [7:0]               SC_RANDQ_rejectCount_OutBUS
);

   localparam int unsigned         LIMIT  = f_limit(DATAWIDTH, RANGE);
   localparam logic [DATAWIDTH:0]   LimitW = (DATAWIDTH + 1)'(LIMIT);
   localparam logic [DATAWIDTH-1:0] RangeW = DATAWIDTH'(RANGE);

   logic [1:0]           r_state;
   logic [1:0]           w_state_next;
   logic [DATAWIDTH-1:0] r_acc;
   logic [DATAWIDTH-1:0] w_acc_next;
   logic                 r_overrun;
   logic                 w_overrun_next;
   logic [7:0]           r_reject_cnt;
   logic [7:0]           w_reject_base;
   logic [7:0]           w_reject_next;
   logic                 w_idle;
   logic                 w_in_range;
   logic                 w_accept;
   logic                 w_reject;
   logic                 w_fifo_push;
   logic                 w_fifo_pop;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_space;

   assign w_idle     = (r_state == StIdle);
   assign w_in_range = ({1'b0, SC_RANDQ_random_InBUS} < LimitW);
   assign w_accept   = SC_RANDQ_sampleTick_In && w_idle && w_in_range;
   assign w_reject   = SC_RANDQ_sampleTick_In && w_idle && !w_in_range;
   assign w_fifo_pop = SC_RANDQ_ready_In && !w_fifo_empty;
   assign w_space    = !w_fifo_full || w_fifo_pop;

   // Sampler FSM and reduction accumulator next state
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_fifo_push  = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_acc_next   = SC_RANDQ_random_InBUS;
               w_state_next = StReduce;
            end
         end
         StReduce: begin
            if (r_acc >= RangeW) w_acc_next   = r_acc - RangeW;
            else                 w_state_next = StPush;
         end
         StPush: begin
            if (w_space) begin
               w_fifo_push  = 1'b1;
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Sticky flags: a set event in the same cycle as clear takes priority
   always_comb begin
      w_overrun_next = r_overrun;
      if (SC_RANDQ_clear_In) w_overrun_next = 1'b0;
      if (SC_RANDQ_sampleTick_In && !w_idle) w_overrun_next = 1'b1;
      w_reject_base = SC_RANDQ_clear_In ? 8'd0 : r_reject_cnt;
      w_reject_next = w_reject_base;
      if (w_reject && (w_reject_base != 8'hFF)) w_reject_next = w_reject_base + 8'd1;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge SC_RANDQ_CLOCK_50) begin
      if (!SC_RANDQ_RESET_InLow) begin
         r_state      <= StIdle;
         r_acc        <= '0;
         r_overrun    <= 1'b0;
         r_reject_cnt <= '0;
      end else begin
         r_state      <= w_state_next;
         r_acc        <= w_acc_next;
         r_overrun    <= w_overrun_next;
         r_reject_cnt <= w_reject_next;
      end
   end

   sc_randq_fifo #(
      .DEPTH    (DEPTH),
      .IDXWIDTH (IDXWIDTH)
   ) u_fifo (
      .i_clk   (SC_RANDQ_CLOCK_50),
      .i_rst_n (SC_RANDQ_RESET_InLow),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_wdata (r_acc[IDXWIDTH-1:0]),
      .o_head  (SC_RANDQ_data_OutBUS),
      .o_count (SC_RANDQ_count_OutBUS),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign SC_RANDQ_valid_Out          = !w_fifo_empty;
   assign SC_RANDQ_busy_Out           = !w_idle;
   assign SC_RANDQ_overrun_Out        = r_overrun;
   assign SC_RANDQ_rejectCount_OutBUS = r_reject_cnt;

endmodule

// File: tb/tb_sc_randq_range_sampler.sv
// Self-checking bench for sc_randq_range_sampler: per-feature tasks plus a scoreboard that
// checks every popped index against the expected (v mod 6) sequence.
module tb_sc_randq_range_sampler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] random;
   logic       tick;
   logic       clear;
   logic       ready;
   logic [2:0] data;
   logic       valid;
   logic [2:0] count;
   logic       busy;
   logic       overrun;
   logic [7:0] reject_cnt;

   int checks   = 0;
   int failures = 0;
   logic [2:0] exp_q[$];

   sc_randq_range_sampler dut (
      .SC_RANDQ_CLOCK_50           (clk),
      .SC_RANDQ_RESET_InLow        (rst_n),
      .SC_RANDQ_random_InBUS       (random),
      .SC_RANDQ_sampleTick_In      (tick),
      .SC_RANDQ_clear_In           (clear),
      .SC_RANDQ_ready_In           (ready),
      .SC_RANDQ_data_OutBUS        (data),
      .SC_RANDQ_valid_Out          (valid),
      .SC_RANDQ_count_OutBUS       (count),
      .SC_RANDQ_busy_Out           (busy),
      .SC_RANDQ_overrun_Out        (overrun),
      .SC_RANDQ_rejectCount_OutBUS (reject_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: every handshake seen before the popping edge must match the queue front
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_unexpected: got data=%0d, expected no entry", data);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if (data !== e) begin
               failures++;
               $display("FAIL scoreboard_data: got %0d, expected %0d", data, e);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic [7:0] v);
      random = v;
      tick   = 1'b1;
      step();
      tick   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300 && busy; i++) step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_timeout: busy=%b, expected 0", name, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; random = '0; tick = 1'b0; clear = 1'b0; ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      do_tick(8'd200);
      step(); step();
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL reset_pre_busy: got %b, expected 1", busy);
      end
      rst_n = 1'b0;
      step(); step();
      checks++;
      if ({data, valid, count, busy, overrun, reject_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: data=%0d valid=%b count=%0d busy=%b ovr=%b rej=%0d, expected all 0",
                  data, valid, count, busy, overrun, reject_cnt);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 45; i++) step();
      checks++;
      if (valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard: valid=%b count=%0d busy=%b, expected 0 0 0", valid, count, busy);
      end
   endtask

   task automatic test_basic();
      ready = 1'b0;
      do_tick(8'd20);
      exp_q.push_back(3'd2);
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++;
         if (valid !== (k == 5)) begin
            failures++;
            $display("FAIL basic_latency_edge%0d: valid=%b, expected %b", k, valid, (k == 5));
         end
      end
      checks++;
      if (data !== 3'd2) begin
         failures++; $display("FAIL basic_head: got %0d, expected 2", data);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0 || count !== 3'd0 || data !== 3'd2) begin
         failures++;
         $display("FAIL basic_pop: valid=%b count=%0d data=%0d, expected 0 0 2", valid, count, data);
      end
   endtask

   task automatic test_reject();
      do_tick(8'd253);
      checks++;
      if (reject_cnt !== 8'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reject_single: rej=%0d busy=%b, expected 1 0", reject_cnt, busy);
      end
      random = 8'd255;
      tick   = 1'b1;
      for (int i = 0; i < 300; i++) step();
      tick   = 1'b0;
      step();
      checks++;
      if (reject_cnt !== 8'd255 || count !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reject_saturate: rej=%0d count=%0d busy=%b, expected 255 0 0",
                  reject_cnt, count, busy);
      end
   endtask

   task automatic test_full_backpressure();
      logic [7:0] vals[4] = '{8'd0, 8'd7, 8'd14, 8'd21};
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_tick(vals[i]);
         exp_q.push_back(3'(vals[i] % 6));
         wait_idle("full_fill");
         checks++;
         if (count !== 3'(i + 1)) begin
            failures++; $display("FAIL full_count%0d: got %0d, expected %0d", i, count, i + 1);
         end
      end
      checks++;
      if (data !== 3'd0) begin
         failures++; $display("FAIL full_head: got %0d, expected 0", data);
      end
      do_tick(8'd5);
      exp_q.push_back(3'd5);
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (busy !== 1'b1 || count !== 3'd4) begin
         failures++;
         $display("FAIL full_hold: busy=%b count=%0d, expected 1 4", busy, count);
      end
      do_tick(8'd9);
      checks++;
      if (overrun !== 1'b1) begin
         failures++; $display("FAIL full_overrun: got %b, expected 1", overrun);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      checks++;
      if (count !== 3'd4 || busy !== 1'b0 || data !== 3'd1) begin
         failures++;
         $display("FAIL full_pop_push: count=%0d busy=%b data=%0d, expected 4 0 1", count, busy, data);
      end
      ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      ready = 1'b0;
      checks++;
      if (count !== 3'd0 || valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL full_drain: count=%0d valid=%b pending=%0d, expected 0 0 0",
                  count, valid, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v;
         v = 8'($urandom_range(0, 251));
         do_tick(v);
         exp_q.push_back(3'(v % 6));
         wait_idle("wrap");
      end
      step(); step(); step();
      checks++;
      if (exp_q.size() != 0 || count !== 3'd0) begin
         failures++;
         $display("FAIL wrap_all_delivered: pending=%0d count=%0d, expected 0 0", exp_q.size(), count);
      end
   endtask

   task automatic test_clear();
      ready = 1'b1;
      do_tick(8'd250);
      exp_q.push_back(3'd4);
      tick  = 1'b1;
      clear = 1'b1;
      step();
      tick  = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         failures++; $display("FAIL clear_vs_overrun: got %b, expected 1", overrun);
      end
      step();
      clear = 1'b0;
      checks++;
      if (overrun !== 1'b0 || reject_cnt !== 8'd0) begin
         failures++;
         $display("FAIL clear_alone: ovr=%b rej=%0d, expected 0 0", overrun, reject_cnt);
      end
      wait_idle("clear");
      random = 8'd253;
      tick   = 1'b1;
      step();
      random = 8'd253;
      clear  = 1'b1;
      step();
      tick   = 1'b0;
      clear  = 1'b0;
      checks++;
      if (reject_cnt !== 8'd1) begin
         failures++; $display("FAIL clear_vs_reject: got %0d, expected 1", reject_cnt);
      end
      step(); step(); step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL clear_sample_lost: pending=%0d, expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reject();
      test_full_backpressure();
      test_wrap();
      test_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
